push_conditioner: RTL and testbench

PUSH_CONDITIONER -- requirements
Module: push_conditioner

---
 rtl/push_conditioner.sv | 103 ++++++++++
 tb/tb_push_conditioner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/push_conditioner.sv
// Per-channel push input conditioner: synchronizer, debouncer,
// edge pulses and a sticky press-event flag with overrun detection.
module push_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] push,
    input  logic [CHANNELS-1:0] press_ack,
    output logic [CHANNELS-1:0] sypush,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press_valid,
    output logic [CHANNELS-1:0] overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0]    r_cnt  [CHANNELS];
    logic [CNT_W-1:0]    w_cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] r_sy;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] r_pv;
    logic [CHANNELS-1:0] r_ov;
    logic [CHANNELS-1:0] w_sync_out;
    logic [CHANNELS-1:0] w_diff;
    logic [CHANNELS-1:0] w_toggle;
    logic [CHANNELS-1:0] w_rise_evt;
    logic [CHANNELS-1:0] w_fall_evt;
    logic [CHANNELS-1:0] w_ack;
    logic [CHANNELS-1:0] w_pv_nxt;
    logic [CHANNELS-1:0] w_ov_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= push;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Count consecutive disagreeing cycles; any agreement restarts it.
    always_comb begin
        w_diff   = w_sync_out ^ r_sy;
        w_toggle = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cnt_nxt[i] = '0;
            w_toggle[i]  = w_diff[i] && (r_cnt[i] == CNT_LAST);
            if (w_diff[i] && !w_toggle[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    assign w_rise_evt = w_toggle & ~r_sy;
    assign w_fall_evt = w_toggle & r_sy;
    assign w_ack      = press_ack & r_pv;

    // An acknowledge always clears overrun, even when a new press lands.
    assign w_pv_nxt = w_rise_evt | (r_pv & ~w_ack);
    assign w_ov_nxt = (r_ov & ~w_ack) | (w_rise_evt & r_pv & ~press_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
            r_sy   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_pv   <= '0;
            r_ov   <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_sy   <= r_sy ^ w_toggle;
            r_rise <= w_rise_evt;
            r_fall <= w_fall_evt;
            r_pv   <= w_pv_nxt;
            r_ov   <= w_ov_nxt;
        end
    end

    assign sypush      = r_sy;
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign press_valid = r_pv;
    assign overrun     = r_ov;

endmodule

// File: tb/tb_push_conditioner.sv
// Vector table + scoreboard bench for push_conditioner
// (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_push_conditioner;

    typedef struct {
        logic [3:0] push;
        logic [3:0] ack;
        int         reps;
        logic [3:0] sy;
        logic [3:0] rs;
        logic [3:0] fl;
        logic [3:0] pv;
        logic [3:0] ov;
    } vec_t;

    typedef struct {
        logic [3:0] sy;
        logic [3:0] rs;
        logic [3:0] fl;
        logic [3:0] pv;
        logic [3:0] ov;
    } exp_t;

    logic       clk = 0;
    logic       rst = 1;
    logic [3:0] push = '0;
    logic [3:0] press_ack = '0;
    logic [3:0] sypush, rise, fall, press_valid, overrun;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[26];
    exp_t sb[$];

    push_conditioner #(
        .CHANNELS(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .press_ack(press_ack),
        .sypush(sypush),
        .rise(rise),
        .fall(fall),
        .press_valid(press_valid),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".sypush"}, sypush, e.sy);
        chk({tag, ".rise"}, rise, e.rs);
        chk({tag, ".fall"}, fall, e.fl);
        chk({tag, ".press_valid"}, press_valid, e.pv);
        chk({tag, ".overrun"}, overrun, e.ov);
    endtask

    task automatic step_exp(input string tag, input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            chk_all(tag, sb.pop_front());
        end
    endtask

    exp_t zero;
    exp_t e;

    initial begin
        zero = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        //          push  ack  n  sy    rise  fall  pv    ov
        vecs[0]  = '{4'h1, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'h1, 4'h0, 1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0};
        vecs[2]  = '{4'h1, 4'h0, 1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
        vecs[3]  = '{4'h3, 4'h0, 3, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
        vecs[4]  = '{4'h1, 4'h0, 6, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
        vecs[5]  = '{4'h0, 4'h0, 5, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
        vecs[6]  = '{4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
        vecs[7]  = '{4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        vecs[8]  = '{4'h0, 4'h1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[9]  = '{4'h0, 4'h1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[10] = '{4'h4, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[11] = '{4'h4, 4'h0, 1, 4'h4, 4'h4, 4'h0, 4'h4, 4'h0};
        vecs[12] = '{4'h0, 4'h0, 5, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0};
        vecs[13] = '{4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};
        vecs[14] = '{4'h4, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
        vecs[15] = '{4'h4, 4'h0, 1, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4};
        vecs[16] = '{4'h4, 4'h4, 1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[17] = '{4'h0, 4'h0, 5, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[18] = '{4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0};
        vecs[19] = '{4'h8, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[20] = '{4'h8, 4'h0, 1, 4'h8, 4'h8, 4'h0, 4'h8, 4'h0};
        vecs[21] = '{4'h0, 4'h0, 5, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0};
        vecs[22] = '{4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0};
        vecs[23] = '{4'h8, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
        vecs[24] = '{4'h8, 4'h8, 1, 4'h8, 4'h8, 4'h0, 4'h8, 4'h0};
        vecs[25] = '{4'h8, 4'h8, 1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};

        #1;
        chk_all("reset", zero);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        for (int v = 0; v < 26; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                push      = vecs[v].push;
                press_ack = vecs[v].ack;
                e = '{vecs[v].sy, vecs[v].rs, vecs[v].fl,
                      vecs[v].pv, vecs[v].ov};
                step_exp($sformatf("vec%0d.%0d", v, r), e);
            end
        end

        // Async reset with no clock edge: ch3 sypush was 1.
        #2;
        rst = 1;
        #1;
        chk_all("async_rst", zero);
        push      = 4'hF;
        press_ack = 4'hF;
        step_exp("rst_hold0", zero);
        step_exp("rst_hold1", zero);

        // Push held through reset, reset again mid-debounce.
        push      = 4'h1;
        press_ack = 4'h0;
        @(negedge clk);
        rst = 0;
        for (int k = 1; k <= 4; k++) begin
            step_exp($sformatf("pre_mid%0d", k), zero);
        end
        #2;
        rst = 1;
        #1;
        chk_all("mid_rst", zero);
        @(negedge clk);
        rst = 0;
        for (int k = 1; k <= 5; k++) begin
            step_exp($sformatf("post_rst%0d", k), zero);
        end
        e = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h0};
        step_exp("post_rst6", e);
        e = '{4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
        step_exp("post_rst7", e);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
